pit8253_sequencer: RTL and testbench
====================================

// Module: pit8253_sequencer
// PURPOSE
//  Shares the pit8253 host bus between three requesters (one per timer channel). Each request
//  is either a program command (control word, LSB, MSB; rl=11) or a latched read-back
//  (latch command, LSB read, MSB read). Sits between the sound/test controllers and pit8253.
//  Keeps one whole command sequence atomic on the bus, so a second requester cannot split an
//  LSB/MSB pair. Arbitration is round-robin.
// PARAMETERS
//  BCD        0   value written to control word bit 0 for every program command
//  RR_START   0   channel index that holds first priority after reset
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  ce         in   1   pit8253 bus clock enable; all writes align to it
//  tce        in   1   pit8253 timer clock enable; read strobes align to it
//  req        in   3   per-channel request, level; held until ack
//  req_rd     in   3   per-channel op: 0 = program, 1 = latched read-back
//  req_mode   in   9   3 bits per channel (ch n at [3n+2:3n]), PIT mode 0..5
//  req_count  in   48  16 bits per channel (ch n at [16n+15:16n]), initial count
//  ack        out  3   one-clk pulse: sequence of that channel complete
//  rd_value   out  16  read-back count; valid while rd_valid is high
//  rd_valid   out  1   one-clk pulse together with ack of a read request
//  busy       out  1   a sequence is in progress
//  pit_a      out  2   to pit8253 a
//  pit_din    out  8   to pit8253 din
//  pit_wr     out  1   to pit8253 wr
//  pit_rd     out  1   to pit8253 rd
//  pit_dout   in   8   from pit8253 dout
// BEHAVIOUR
//  Reset: state IDLE, rr pointer=RR_START. ack=0, rd_valid=0, busy=0, pit_wr=0, pit_rd=0,
//   pit_a=2'b11, pit_din=0, rd_value=0.
//  FSM: IDLE, GRANT, CW, LSB, MSB, LATCH, RDL, RDM, DONE.
//  IDLE: if any req, register the winner. Search order is rr, rr+1, rr+2 (mod 3).
//   Then go to GRANT and latch that channel's op, mode and count; busy=1.
//  GRANT: go to CW for a program request, or LATCH for a read request.
//  Write states (CW, LSB, MSB, LATCH): pit_a and pit_din are registered on state entry.
//   pit_wr = ce & in-write-state (combinational), so exactly one clk cycle coincides with ce.
//   Advance on that ce cycle. Minimum 1 ce per write; no back-to-back writes inside one ce.
//   CW    : a=3, din={ch[1:0],2'b11,mode[2:0],BCD}                       -> LSB
//   LSB   : a=ch, din=count[7:0]                                        -> MSB
//   MSB   : a=ch, din=count[15:8]                                       -> DONE
//   LATCH : a=3, din={ch[1:0],6'b000000}                                 -> RDL
//  Read states (RDL, RDM): a=ch, pit_rd=1 from state entry.
//   On the first cycle with tce&pit_rd: capture pit_dout into rd_value[7:0] (RDL) or
//   [15:8] (RDM), deassert pit_rd for one cycle, then advance: RDL->RDM, RDM->DONE.
//  DONE: pulse ack[ch] for one clk. Pulse rd_valid too for reads. Set rr=ch+1 (mod 3).
//   busy=0, go to IDLE. A requester deasserts req in the cycle after ack.
//   A req still high 2 cycles after ack counts as a new request.
//  A req dropped mid-sequence has no effect; the sequence completes and ack still pulses.
//  Invalid req_mode 6/7 is passed through unchanged (PIT treats them as M2X/M3X).
//  Channel index 3 is never generated. Index arithmetic is 2-bit, wrapping 2->0.
//  reset mid-sequence: immediate return to reset values. The partial PIT write is abandoned;
//   the PIT stays waiting for its MSB until next programmed.
// STRUCTURE
//  Shared package pit_pkg: FSM state enum, PIT_CW_ADDR=2'b11, RL_LSBMSB=2'b11, RL_LATCH=2'b00,
//   and mode constants M0..M5.
//  One sub-module: pit_rr_arbiter (3-way round-robin, one-hot grant + 2-bit index, pointer update
//   on done). Everything else is in the top FSM.
// TESTING
//  ch1 program mode3 count 0x1234, ce every 2nd clk -> writes (3,0x76),(1,0x34),(1,0x12) each
//   one clk on ce; ack[1] pulses after the 3rd write.
//  req=3'b111 together, all program -> order ch0,ch1,ch2; nine writes; no interleave on pit_a.
//  ch2 read-back, PIT counter=0xBEEF -> write (3,0x80), two rd strobes on tce;
//   rd_value=0xBEEF with rd_valid and ack[2] in the same clk.
//  After ch2 is served, req=3'b101 -> ch0 is granted next (round-robin wrap 2->0).
//  reset asserted during LSB state -> pit_wr=0 and busy=0 immediately; next request restarts at CW.
//  ce held low 20 clks in CW -> pit_wr stays 0 and the FSM holds; the write occurs on the first ce.

Source files
------------

// File: rtl/pit8253_sequencer_pkg.sv
// pit_pkg: shared definitions for the pit8253 bus sequencer.
//   state_t      - sequencer FSM states
//   PIT_CW_ADDR  - pit8253 address of the control-word register
//   RL_*         - read/load field values for the control word
//   M0..M5       - PIT counting modes
//   idx_inc      - 2-bit channel index increment, wrapping 2 -> 0
//   bit_at       - select one request bit by channel index
//   idx_onehot   - channel index to one-hot vector
package pit_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_GRANT = 4'd1,
    S_CW    = 4'd2,
    S_LSB   = 4'd3,
    S_MSB   = 4'd4,
    S_LATCH = 4'd5,
    S_RDL   = 4'd6,
    S_RDM   = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  localparam logic [1:0] PIT_CW_ADDR = 2'b11;
  localparam logic [1:0] RL_LSBMSB   = 2'b11;
  localparam logic [1:0] RL_LATCH    = 2'b00;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  // Only channels 0..2 exist, so index 2 (and the unused 3) wrap to 0.
  function automatic logic [1:0] idx_inc(input logic [1:0] i);
    case (i)
      2'd0:    idx_inc = 2'd1;
      2'd1:    idx_inc = 2'd2;
      default: idx_inc = 2'd0;
    endcase
  endfunction

  function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    bit_at = v[0];
      2'd1:    bit_at = v[1];
      2'd2:    bit_at = v[2];
      default: bit_at = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] idx_onehot(input logic [1:0] i);
    case (i)
      2'd0:    idx_onehot = 3'b001;
      2'd1:    idx_onehot = 3'b010;
      2'd2:    idx_onehot = 3'b100;
      default: idx_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/pit8253_sequencer_if.sv
// pit8253 host-bus interface.
//   pit_a, pit_din, pit_wr, pit_rd : sequencer -> pit8253
//   pit_dout                       : pit8253 -> sequencer
// master modport is the sequencer, slave modport is the pit8253 side.
interface pit8253_sequencer_if;
  logic [1:0] pit_a;
  logic [7:0] pit_din;
  logic       pit_wr;
  logic       pit_rd;
  logic [7:0] pit_dout;

  modport master (output pit_a, output pit_din, output pit_wr, output pit_rd, input pit_dout);
  modport slave  (input pit_a, input pit_din, input pit_wr, input pit_rd, output pit_dout);
endinterface

// File: rtl/pit8253_sequencer_arbiter.sv
// pit_rr_arbiter: 3-way round-robin arbiter.
//   clk, reset   : clock, async active-high reset
//   req          : per-channel request
//   done         : sequence complete, advance pointer past done_idx
//   done_idx     : channel that just completed
//   grant        : one-hot winner (zero when no request)
//   grant_idx    : 2-bit index of the winner
//   grant_valid  : some request is pending
module pit_rr_arbiter
  import pit_pkg::*;
#(
  parameter logic [1:0] RR_START = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       done,
  input  logic [1:0] done_idx,
  output logic [2:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid
);

  logic [1:0] rr_r;
  logic [1:0] idx1_s;
  logic [1:0] idx2_s;
  logic [1:0] sel_s;
  logic       valid_s;

  // Priority pointer: moves to the channel after the one just served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_r <= RR_START;
    end else if (done) begin
      rr_r <= idx_inc(done_idx);
    end else begin
      rr_r <= rr_r;
    end
  end

  // Search rr, rr+1, rr+2 (mod 3) for the first pending request.
  always_comb begin
    idx1_s  = idx_inc(rr_r);
    idx2_s  = idx_inc(idx1_s);
    sel_s   = rr_r;
    valid_s = 1'b1;
    if (bit_at(req, rr_r)) begin
      sel_s = rr_r;
    end else if (bit_at(req, idx1_s)) begin
      sel_s = idx1_s;
    end else if (bit_at(req, idx2_s)) begin
      sel_s = idx2_s;
    end else begin
      sel_s   = rr_r;
      valid_s = 1'b0;
    end
  end

  assign grant       = valid_s ? idx_onehot(sel_s) : 3'b000;
  assign grant_idx   = sel_s;
  assign grant_valid = valid_s;

endmodule

// File: rtl/pit8253_sequencer.sv
// pit8253_sequencer: shares the pit8253 host bus between three requesters,
// keeping each program (CW/LSB/MSB) or read-back (latch/LSB/MSB) sequence atomic.
//   clk, reset : clock, async active-high reset
//   ce, tce    : pit8253 bus / timer clock enables
//   req        : per-channel level request, held until ack
//   req_rd     : per-channel op, 0 program, 1 latched read-back
//   req_mode   : 3 bits per channel, PIT mode
//   req_count  : 16 bits per channel, initial count
//   ack        : one-clk pulse when a channel's sequence completes
//   rd_value   : read-back count, valid with rd_valid
//   rd_valid   : one-clk pulse with ack of a read request
//   busy       : a sequence is in progress
//   pit        : pit8253 host bus (master side)
module pit8253_sequencer
  import pit_pkg::*;
#(
  parameter logic       BCD      = 1'b0,
  parameter logic [1:0] RR_START = 2'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ce,
  input  logic                       tce,
  input  logic [2:0]                 req,
  input  logic [2:0]                 req_rd,
  input  logic [8:0]                 req_mode,
  input  logic [47:0]                req_count,
  output logic [2:0]                 ack,
  output logic [15:0]                rd_value,
  output logic                       rd_valid,
  output logic                       busy,
  pit8253_sequencer_if.master        pit
);

  state_t      state_r, state_s;
  logic [1:0]  ch_r, ch_s;
  logic [2:0]  ch_oh_r, ch_oh_s;
  logic        op_rd_r, op_rd_s;
  logic [2:0]  mode_r, mode_s;
  logic [15:0] count_r, count_s;
  logic [1:0]  a_r, a_s;
  logic [7:0]  din_r, din_s;
  logic        rd_r, rd_s;
  logic [15:0] rd_value_r, rd_value_s;
  logic [2:0]  ack_r, ack_s;
  logic        rd_valid_r, rd_valid_s;
  logic        busy_r, busy_s;
  logic [2:0]  ack_mask_r;

  logic [2:0]  req_eff_s;
  logic [2:0]  gnt_s;
  logic [1:0]  gnt_idx_s;
  logic        gnt_valid_s;
  logic        sel_rd_s;
  logic [2:0]  sel_mode_s;
  logic [15:0] sel_count_s;
  logic        wr_state_s;

  // A requester may still hold req in the cycle after its ack; ignore it then.
  assign req_eff_s = req & ~ack_mask_r;

  pit_rr_arbiter #(.RR_START(RR_START)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (req_eff_s),
    .done        (state_r == S_DONE),
    .done_idx    (ch_r),
    .grant       (gnt_s),
    .grant_idx   (gnt_idx_s),
    .grant_valid (gnt_valid_s)
  );

  // Pick the winning channel's op, mode and count.
  always_comb begin
    case (gnt_idx_s)
      2'd1: begin
        sel_rd_s    = req_rd[1];
        sel_mode_s  = req_mode[5:3];
        sel_count_s = req_count[31:16];
      end
      2'd2: begin
        sel_rd_s    = req_rd[2];
        sel_mode_s  = req_mode[8:6];
        sel_count_s = req_count[47:32];
      end
      default: begin
        sel_rd_s    = req_rd[0];
        sel_mode_s  = req_mode[2:0];
        sel_count_s = req_count[15:0];
      end
    endcase
  end

  // The write strobe is gated by ce so it covers exactly the one ce cycle.
  assign wr_state_s = (state_r == S_CW) || (state_r == S_LSB) ||
                      (state_r == S_MSB) || (state_r == S_LATCH);
  assign pit.pit_wr = ce & wr_state_s;

  // Next-state and next-output logic; bus values are set on entry to each state.
  always_comb begin
    state_s    = state_r;
    ch_s       = ch_r;
    ch_oh_s    = ch_oh_r;
    op_rd_s    = op_rd_r;
    mode_s     = mode_r;
    count_s    = count_r;
    a_s        = a_r;
    din_s      = din_r;
    rd_s       = rd_r;
    rd_value_s = rd_value_r;
    ack_s      = 3'b000;
    rd_valid_s = 1'b0;
    busy_s     = busy_r;
    case (state_r)
      S_IDLE: begin
        if (gnt_valid_s) begin
          state_s = S_GRANT;
          ch_s    = gnt_idx_s;
          ch_oh_s = gnt_s;
          op_rd_s = sel_rd_s;
          mode_s  = sel_mode_s;
          count_s = sel_count_s;
          busy_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_GRANT: begin
        a_s = PIT_CW_ADDR;
        if (op_rd_r) begin
          state_s = S_LATCH;
          din_s   = {ch_r, RL_LATCH, 4'b0000};
        end else begin
          state_s = S_CW;
          din_s   = {ch_r, RL_LSBMSB, mode_r, BCD};
        end
      end
      S_CW: begin
        if (ce) begin
          state_s = S_LSB;
          a_s     = ch_r;
          din_s   = count_r[7:0];
        end else begin
          state_s = S_CW;
        end
      end
      S_LSB: begin
        if (ce) begin
          state_s = S_MSB;
          din_s   = count_r[15:8];
        end else begin
          state_s = S_LSB;
        end
      end
      S_MSB: begin
        if (ce) begin
          state_s = S_DONE;
          ack_s   = ch_oh_r;
          busy_s  = 1'b0;
          a_s     = PIT_CW_ADDR;
          din_s   = 8'h00;
        end else begin
          state_s = S_MSB;
        end
      end
      S_LATCH: begin
        if (ce) begin
          state_s = S_RDL;
          a_s     = ch_r;
          din_s   = 8'h00;
          rd_s    = 1'b1;
        end else begin
          state_s = S_LATCH;
        end
      end
      S_RDL: begin
        // Capture on the strobe, hold rd low one cycle, then start the MSB read.
        if (rd_r) begin
          if (tce) begin
            rd_value_s[7:0] = pit.pit_dout;
            rd_s            = 1'b0;
          end else begin
            rd_s = 1'b1;
          end
        end else begin
          state_s = S_RDM;
          rd_s    = 1'b1;
        end
      end
      S_RDM: begin
        if (rd_r) begin
          if (tce) begin
            rd_value_s[15:8] = pit.pit_dout;
            rd_s             = 1'b0;
          end else begin
            rd_s = 1'b1;
          end
        end else begin
          state_s    = S_DONE;
          ack_s      = ch_oh_r;
          rd_valid_s = 1'b1;
          busy_s     = 1'b0;
          a_s        = PIT_CW_ADDR;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      ch_r       <= 2'd0;
      ch_oh_r    <= 3'b000;
      op_rd_r    <= 1'b0;
      mode_r     <= 3'd0;
      count_r    <= 16'h0000;
      a_r        <= PIT_CW_ADDR;
      din_r      <= 8'h00;
      rd_r       <= 1'b0;
      rd_value_r <= 16'h0000;
      ack_r      <= 3'b000;
      rd_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      ack_mask_r <= 3'b000;
    end else begin
      state_r    <= state_s;
      ch_r       <= ch_s;
      ch_oh_r    <= ch_oh_s;
      op_rd_r    <= op_rd_s;
      mode_r     <= mode_s;
      count_r    <= count_s;
      a_r        <= a_s;
      din_r      <= din_s;
      rd_r       <= rd_s;
      rd_value_r <= rd_value_s;
      ack_r      <= ack_s;
      rd_valid_r <= rd_valid_s;
      busy_r     <= busy_s;
      ack_mask_r <= ack_r;
    end
  end

  assign ack        = ack_r;
  assign rd_value   = rd_value_r;
  assign rd_valid   = rd_valid_r;
  assign busy       = busy_r;
  assign pit.pit_a  = a_r;
  assign pit.pit_din = din_r;
  assign pit.pit_rd = rd_r;

endmodule

// File: tb/tb_pit8253_sequencer.sv
// Self-checking bench for pit8253_sequencer: expected bus writes and acks are
// queued when a request is raised and compared as the DUT produces them.
module tb_pit8253_sequencer;

  typedef struct packed {
    logic [1:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct packed {
    logic [2:0]  ack;
    logic        rd;
    logic [15:0] val;
  } ack_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        tce = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  req_rd = 3'b000;
  logic [8:0]  req_mode = 9'd0;
  logic [47:0] req_count = 48'd0;
  logic [2:0]  ack;
  logic [15:0] rd_value;
  logic        rd_valid;
  logic        busy;
  logic        rd_sel;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ce_div = 2;
  int rd_strobes = 0;
  bit ce_force_low = 1'b0;

  wr_t  exp_wr[$];
  ack_t exp_ack[$];

  pit8253_sequencer_if bus();

  // Counter value 0xBEEF: LSB first after a latch command, then MSB.
  assign bus.pit_dout = rd_sel ? 8'hBE : 8'hEF;

  pit8253_sequencer #(.BCD(1'b0), .RR_START(2'd0)) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .tce       (tce),
    .req       (req),
    .req_rd    (req_rd),
    .req_mode  (req_mode),
    .req_count (req_count),
    .ack       (ack),
    .rd_value  (rd_value),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .pit       (bus)
  );

  always #5 clk = ~clk;

  // Clock-enable generator: ce every ce_div clocks, tce every 3rd clock.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    ce  = (!ce_force_low) && ((cyc % ce_div) == 0);
    tce = ((cyc % 3) == 0);
  end

  // Minimal PIT read model: latch command resets byte order, each rd strobe flips it.
  always @(posedge clk) begin
    if (reset) rd_sel <= 1'b0;
    else if (bus.pit_wr && bus.pit_a == 2'b11) rd_sel <= 1'b0;
    else if (bus.pit_rd && tce) rd_sel <= ~rd_sel;
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t  w;
    ack_t e;
    if (!reset) begin
      if (bus.pit_wr) begin
        checks = checks + 1;
        if (ce !== 1'b1) begin
          errors = errors + 1;
          $display("FAIL wr_on_ce: ce=%0b required 1", ce);
        end
        checks = checks + 1;
        if (exp_wr.size() == 0) begin
          errors = errors + 1;
          $display("FAIL wr_unexpected: a=%0d din=%h required no write", bus.pit_a, bus.pit_din);
        end else begin
          w = exp_wr.pop_front();
          if (bus.pit_a !== w.a || bus.pit_din !== w.d) begin
            errors = errors + 1;
            $display("FAIL wr_data: got (%0d,%h) required (%0d,%h)", bus.pit_a, bus.pit_din, w.a, w.d);
          end
        end
      end
      if (bus.pit_rd && tce) rd_strobes = rd_strobes + 1;
      if (ack !== 3'b000) begin
        checks = checks + 1;
        if (exp_ack.size() == 0) begin
          errors = errors + 1;
          $display("FAIL ack_unexpected: ack=%b required none", ack);
        end else begin
          e = exp_ack.pop_front();
          if (ack !== e.ack || rd_valid !== e.rd || (e.rd && rd_value !== e.val)) begin
            errors = errors + 1;
            $display("FAIL ack_data: got ack=%b rd_valid=%0b rd_value=%h required ack=%b rd_valid=%0b rd_value=%h",
                     ack, rd_valid, rd_value, e.ack, e.rd, e.val);
          end
        end
      end else if (rd_valid !== 1'b0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL rd_valid_alone: rd_valid=%0b required 0 without ack", rd_valid);
      end
    end
  end

  task automatic push_prog(input int ch, input logic [2:0] mode, input logic [15:0] count);
    wr_t  w;
    ack_t e;
    logic [1:0] c;
    c = ch[1:0];
    w.a = 2'b11; w.d = {c, 2'b11, mode, 1'b0}; exp_wr.push_back(w);
    w.a = c;     w.d = count[7:0];             exp_wr.push_back(w);
    w.a = c;     w.d = count[15:8];            exp_wr.push_back(w);
    e.ack = 3'b001 << ch; e.rd = 1'b0; e.val = 16'h0000;
    exp_ack.push_back(e);
  endtask

  task automatic set_req(input int ch, input logic rd, input logic [2:0] mode, input logic [15:0] count);
    req_rd[ch] = rd;
    req_mode[ch*3 +: 3] = mode;
    req_count[ch*16 +: 16] = count;
    req[ch] = 1'b1;
  endtask

  // Runs until every queued ack has been seen, dropping req bits on their ack.
  task automatic wait_done(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      req = req & ~ack;
      if (exp_ack.size() == 0 && req == 3'b000) begin
        ok = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL %s_timeout: %0d acks pending, required 0", name, exp_ack.size());
      req = 3'b000;
      exp_ack.delete();
    end
    repeat (3) @(posedge clk);
    #2;
    checks = checks + 1;
    if (exp_wr.size() != 0 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL %s_leftover: %0d writes pending busy=%0b required 0 and 0", name, exp_wr.size(), busy);
      exp_wr.delete();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req = 3'b000;
    exp_wr.delete();
    exp_ack.delete();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks = checks + 1;
    if ({ack, rd_valid, busy, bus.pit_wr, bus.pit_rd, bus.pit_a, bus.pit_din, rd_value} !==
        {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8'h00, 16'h0000}) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: ack=%b rv=%0b busy=%0b wr=%0b rd=%0b a=%0d din=%h val=%h required 000 0 0 0 0 3 00 0000",
               ack, rd_valid, busy, bus.pit_wr, bus.pit_rd, bus.pit_a, bus.pit_din, rd_value);
    end
    reset = 1'b0;
  endtask

  task automatic test_program_ch1();
    ce_div = 2;
    push_prog(1, 3'd3, 16'h1234);
    set_req(1, 1'b0, 3'd3, 16'h1234);
    wait_done("program_ch1", 200);
  endtask

  task automatic test_all_three();
    apply_reset();
    ce_div = 3;
    push_prog(0, 3'd0, 16'hFFFF);
    push_prog(1, 3'd5, 16'h0001);
    push_prog(2, 3'd7, 16'h8000);
    set_req(0, 1'b0, 3'd0, 16'hFFFF);
    set_req(1, 1'b0, 3'd5, 16'h0001);
    set_req(2, 1'b0, 3'd7, 16'h8000);
    wait_done("all_three", 400);
  endtask

  task automatic test_readback_ch2();
    wr_t  w;
    ack_t e;
    ce_div = 2;
    rd_strobes = 0;
    w.a = 2'b11; w.d = {2'd2, 6'b000000};
    exp_wr.push_back(w);
    e.ack = 3'b100; e.rd = 1'b1; e.val = 16'hBEEF;
    exp_ack.push_back(e);
    set_req(2, 1'b1, 3'd0, 16'h0000);
    wait_done("readback_ch2", 200);
    checks = checks + 1;
    if (rd_strobes != 2) begin
      errors = errors + 1;
      $display("FAIL readback_strobes: %0d strobes required 2", rd_strobes);
    end
  endtask

  task automatic test_rr_wrap();
    ce_div = 2;
    push_prog(0, 3'd2, 16'hA55A);
    push_prog(2, 3'd4, 16'h0F0F);
    set_req(0, 1'b0, 3'd2, 16'hA55A);
    set_req(2, 1'b0, 3'd4, 16'h0F0F);
    wait_done("rr_wrap", 300);
  endtask

  task automatic test_ce_hold();
    ce_force_low = 1'b1;
    ce_div = 1;
    push_prog(1, 3'd1, 16'h00AA);
    set_req(1, 1'b0, 3'd1, 16'h00AA);
    repeat (20) @(posedge clk);
    #2;
    checks = checks + 1;
    if (busy !== 1'b1 || bus.pit_wr !== 1'b0 || exp_wr.size() != 3) begin
      errors = errors + 1;
      $display("FAIL ce_hold: busy=%0b wr=%0b writes_left=%0d required 1 0 3", busy, bus.pit_wr, exp_wr.size());
    end
    ce_force_low = 1'b0;
    wait_done("ce_hold", 200);
  endtask

  task automatic test_reset_mid();
    bit reached;
    reached = 1'b0;
    ce_div = 4;
    push_prog(0, 3'd2, 16'h5A5A);
    set_req(0, 1'b0, 3'd2, 16'h5A5A);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (exp_wr.size() == 2) begin
        reached = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!reached || busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL reset_mid_reach: reached=%0b busy=%0b required 1 1", reached, busy);
    end
    reset = 1'b1;
    #1;
    checks = checks + 1;
    if (bus.pit_wr !== 1'b0 || busy !== 1'b0 || bus.pit_a !== 2'b11 || rd_value !== 16'h0000) begin
      errors = errors + 1;
      $display("FAIL reset_mid_outputs: wr=%0b busy=%0b a=%0d val=%h required 0 0 3 0000",
               bus.pit_wr, busy, bus.pit_a, rd_value);
    end
    req = 3'b000;
    exp_wr.delete();
    exp_ack.delete();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    push_prog(0, 3'd2, 16'h5A5A);
    set_req(0, 1'b0, 3'd2, 16'h5A5A);
    wait_done("reset_mid_restart", 200);
  endtask

  initial begin
    test_reset();
    test_program_ch1();
    test_all_three();
    test_readback_ch2();
    test_rr_wrap();
    test_ce_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
